// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle 16-bit core over one shared wait-state memory port; define CPU_MC_SAT_EN to saturate ADD/SUB on signed overflow
module cpu_mc #(
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              hlt,
  output logic [ADDR_W-1:0] pc
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [ADDR_W-1:0] PC0  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] EVEN = ~ADDR_W'(1);

  logic [2:0]        state;
  logic              run;
  logic [15:0]       ir, a, b, d, res;
  logic [15:0]       regs [16];
  logic [ADDR_W-1:0] ea;
  logic              fn, fv, fz;
  logic [3:0]        op;
  logic [2:0]        cond;
  logic              sub, ovf, take, to_wb;
  logic [15:0]       bx, sum, arith, rot, alu, off4, off9, ea_full;

  // ALU, address generation and branch condition, all evaluated on the operands latched in DECODE
  always_comb begin
    op      = ir[15:12];
    cond    = ir[11:9];
    sub     = op == 4'h1;
    bx      = sub ? ~b : b;
    sum     = a + bx + 16'(sub);
    ovf     = (a[15] == bx[15]) && (sum[15] != a[15]);
`ifdef CPU_MC_SAT_EN
    arith   = ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : sum;
`else
    arith   = sum;
`endif
    rot     = 16'({a, a} >> ir[3:0]);
    alu     = (op == 4'h0 || op == 4'h1) ? arith :
              op == 4'h2 ? a ^ b :
              op == 4'h4 ? a << ir[3:0] :
              op == 4'h5 ? 16'($signed(a) >>> ir[3:0]) :
              op == 4'h6 ? rot :
              op == 4'hA ? {d[15:8], ir[7:0]} : {ir[7:0], d[7:0]};
    off4    = {{11{ir[3]}}, ir[3:0], 1'b0};
    off9    = {{6{ir[8]}}, ir[8:0], 1'b0};
    ea_full = a + off4;
    take    = cond == 3'd0 ? !fz :
              cond == 3'd1 ? fz :
              cond == 3'd2 ? !fz && !fn :
              cond == 3'd3 ? fn :
              cond == 3'd4 ? fz || !fn :
              cond == 3'd5 ? fn || fz :
              cond == 3'd6 ? fv : 1'b1;
    to_wb   = op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    mem_req   = run && (state == S_FETCH || state == S_MEM);
    mem_we    = mem_req && state == S_MEM && op == 4'h9;
    mem_addr  = !mem_req ? '0 : state == S_MEM ? ea : pc & EVEN;
    mem_wdata = mem_we ? d : '0;
    hlt       = state == S_HALT;
  end

  // Control FSM; run keeps the port idle in the cycle reset is released so a request never overlaps reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      run   <= 1'b0;
      pc    <= PC0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      d     <= '0;
      res   <= '0;
      ea    <= '0;
      fn    <= 1'b0;
      fv    <= 1'b0;
      fz    <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FETCH: if (mem_req && mem_ready) begin
          ir    <= mem_rdata;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a     <= regs[ir[7:4]];
          b     <= regs[ir[3:0]];
          d     <= regs[ir[11:8]];
          state <= op == 4'hF ? S_HALT : S_EXEC;
          if (op != 4'hF) pc <= pc + ADDR_W'(2);
        end
        S_EXEC: begin
          res <= alu;
          ea  <= ea_full[ADDR_W-1:0] & EVEN;
          if (op == 4'h0 || op == 4'h1) begin
            fn <= arith[15];
            fv <= ovf;
            fz <= arith == 16'h0;
          end else if (op inside {4'h2, 4'h4, 4'h5, 4'h6}) fz <= alu == 16'h0;
          if (op == 4'hC && take) pc <= pc + off9[ADDR_W-1:0];
          state <= (op == 4'h8 || op == 4'h9) ? S_MEM : to_wb ? S_WB : S_FETCH;
        end
        S_MEM: if (mem_ready) begin
          res   <= mem_rdata;
          state <= op == 4'h8 ? S_WB : S_FETCH;
        end
        S_WB: state <= S_FETCH;
        default: state <= S_HALT;
      endcase
    end
  end

  // Register file; R0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (state == S_WB && ir[11:8] != 4'h0) begin
      regs[ir[11:8]] <= res;
    end
  end
endmodule
